hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV64 core, placed beside the ID stage (InstructionDecoder, RegisterFile, ImmGen, ControlUnit). It keeps its own shadow copy of the EX, MEM and WB stage metadata (valid, rd, rs1/rs2, RegWrite, MemRead, Branch). From this it drives:
- load-use stalls,
- taken-branch flushes,
- EX operand forwarding selects,
- ID read bypass for same-cycle WB writes,
- saturating stall and flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_AW  rs1 from InstructionDecoder.
- id_rs2  in  REG_AW  rs2 from InstructionDecoder.
- id_uses_rs2  in  1  instruction reads rs2 (R, S, B types).
- id_rd  in  REG_AW  destination register.
- id_regwrite  in  1  ControlUnit RegWrite.
- id_memread  in  1  ControlUnit MemRead.
- id_branch  in  1  ControlUnit Branch.
- ex_branch_taken  in  1  branch comparison result from EX.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to a NOP.
- idex_bubble  out  1  load a NOP into ID/EX instead of the ID instruction.
- fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- id_bypass_a  out  1  select WB writeData in place of readData1.
- id_bypass_b  out  1  select WB writeData in place of readData2.
- stall_count  out  CNT_W  number of load-use stall cycles.
- flush_count  out  CNT_W  number of taken-branch flushes.

Behaviour:
- Reset (asynchronous):
  - ex/mem/wb valid = 0; counters = 0.
  - Outputs settle to pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00, id_bypass_a/b=0.
- Shadow pipeline, advanced every clock: wb <= mem; mem <= ex; ex <= (idex_bubble ? invalid : ID fields, with valid = id_valid). There is no other stall source.
- A register "matches" only when its rd is nonzero and the owning stage has valid=1 and regwrite=1. x0 never matches.
- brflush (combinational) = ex_valid & ex_branch & ex_branch_taken. ex_branch_taken is ignored otherwise.
- lu_stall (combinational) = id_valid & ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- Output priority: brflush over lu_stall.
  - brflush: pc_write=1, ifid_flush=1, idex_bubble=1, ifid_write=1.
  - lu_stall only: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - Neither: defaults (pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0).
- Load-use sequence (exactly one stall cycle):
  - Load in EX and dependent instruction in ID -> stall.
  - Next cycle: EX holds a bubble, so no stall.
  - Following cycle: the dependent instruction is in EX, the load is in WB, and fwd selects 01.
- fwd_a (combinational, from ex_rs1):
  - 10 if it matches mem_rd and mem_memread=0.
  - else 01 if it matches wb_rd.
  - else 00.
  - EX/MEM takes priority over MEM/WB on a double match. A load in MEM never yields 10.
- fwd_b: same rule using ex_rs2, qualified by ex_uses_rs2; forced to 00 when ex_uses_rs2=0.
- id_bypass_a = id_valid & (wb matches id_rs1). id_bypass_b = id_valid & id_uses_rs2 & (wb matches id_rs2). This covers the RegisterFile write-then-read gap in the same cycle.
- Counters:
  - stall_count += 1 on each cycle with lu_stall & !brflush.
  - flush_count += 1 on each cycle with brflush.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush: all shadow stages are dropped at once; outputs return to reset values within the same cycle.

Test Plan:
- Reset held for 2 cycles then released with id_valid=0 -> pc_write=1, ifid_write=1, fwd_a=fwd_b=00, both counters 0.
- ld x1, followed next cycle by add x3,x1,x2 (0x002081B3) -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1. Two cycles later the add is in EX with fwd_a=01, fwd_b=00. stall_count=1.
- add x3,x1,x2 then sub x4,x3,x3 (back to back) -> no stall; with the sub in EX, fwd_a=10 and fwd_b=10. Also repeat with rd=x0 -> fwd stays 00.
- beq x1,x2,12 (0x00208663) reaches EX with ex_branch_taken=1 -> ifid_flush=1, idex_bubble=1, pc_write=1 for one cycle; flush_count=1. The same case with ex_branch_taken=0 -> no flush.
- Load in EX with a dependent instruction in ID, while a taken branch is also asserted in EX (forced) -> flush wins, pc_write=1, stall_count unchanged. Separately: WB writes x5 while ID reads rs1=x5 -> id_bypass_a=1.
- Preload stall_count to all-ones via a forced-stall run with CNT_W=4 -> the counter stays at 4'hF. Reset asserted mid-stall -> pc_write=1 and counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard controller bundle: decoded ID fields and EX branch result in,
// pipeline enables, forwarding/bypass selects and performance counters out.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_branch;
  logic              ex_branch_taken;

  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              id_bypass_a;
  logic              id_bypass_b;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd,
           id_regwrite, id_memread, id_branch, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
           fwd_a, fwd_b, id_bypass_a, id_bypass_b, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd,
           id_regwrite, id_memread, id_branch, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
           fwd_a, fwd_b, id_bypass_a, id_bypass_b, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: shadows EX/MEM/WB metadata to drive load-use
// stalls, taken-branch flushes, EX forwarding, ID bypass and saturating counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);
  logic              r_ex_valid, r_ex_uses_rs2, r_ex_regwrite, r_ex_memread, r_ex_branch;
  logic [REG_AW-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
  logic              r_mem_valid, r_mem_regwrite, r_mem_memread;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_wb_valid, r_wb_regwrite;
  logic [REG_AW-1:0] r_wb_rd;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  logic w_brflush, w_lu_stall, w_bubble, w_mem_wr, w_wb_wr;

  // x0 is never a forwarding/bypass source
  assign w_mem_wr = r_mem_valid & r_mem_regwrite & (r_mem_rd != '0);
  assign w_wb_wr  = r_wb_valid & r_wb_regwrite & (r_wb_rd != '0);

  assign w_brflush  = r_ex_valid & r_ex_branch & hz.ex_branch_taken;
  assign w_lu_stall = hz.id_valid & r_ex_valid & r_ex_memread & (r_ex_rd != '0) &
                      ((r_ex_rd == hz.id_rs1) | (hz.id_uses_rs2 & (r_ex_rd == hz.id_rs2)));
  assign w_bubble   = w_brflush | w_lu_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_uses_rs2  <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_branch    <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_mem_valid    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_rd       <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_rd        <= '0;
    end else begin
      r_wb_valid     <= r_mem_valid;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_rd        <= r_mem_rd;
      r_mem_valid    <= r_ex_valid;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memread  <= r_ex_memread;
      r_mem_rd       <= r_ex_rd;
      if (w_bubble) begin
        r_ex_valid    <= 1'b0;
        r_ex_uses_rs2 <= 1'b0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
        r_ex_branch   <= 1'b0;
        r_ex_rd       <= '0;
        r_ex_rs1      <= '0;
        r_ex_rs2      <= '0;
      end else begin
        r_ex_valid    <= hz.id_valid;
        r_ex_uses_rs2 <= hz.id_uses_rs2;
        r_ex_regwrite <= hz.id_regwrite;
        r_ex_memread  <= hz.id_memread;
        r_ex_branch   <= hz.id_branch;
        r_ex_rd       <= hz.id_rd;
        r_ex_rs1      <= hz.id_rs1;
        r_ex_rs2      <= hz.id_rs2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lu_stall && !w_brflush && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_brflush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    if (w_brflush) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (w_lu_stall) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
    end
  end

  // A load still in MEM has no data yet, so it may only forward from WB
  always_comb begin
    hz.fwd_a = 2'b00;
    if (w_mem_wr && !r_mem_memread && (r_mem_rd == r_ex_rs1))
      hz.fwd_a = 2'b10;
    else if (w_wb_wr && (r_wb_rd == r_ex_rs1))
      hz.fwd_a = 2'b01;
  end

  always_comb begin
    hz.fwd_b = 2'b00;
    if (r_ex_uses_rs2) begin
      if (w_mem_wr && !r_mem_memread && (r_mem_rd == r_ex_rs2))
        hz.fwd_b = 2'b10;
      else if (w_wb_wr && (r_wb_rd == r_ex_rs2))
        hz.fwd_b = 2'b01;
    end
  end

  assign hz.id_bypass_a = hz.id_valid & w_wb_wr & (r_wb_rd == hz.id_rs1);
  assign hz.id_bypass_b = hz.id_valid & hz.id_uses_rs2 & w_wb_wr & (r_wb_rd == hz.id_rs2);
  assign hz.stall_count = r_stall_cnt;
  assign hz.flush_count = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, checked against
// an instruction-level pipeline model; a CNT_W=4 twin exercises counter saturation.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  hs ();

  hazard_ctrl #(.REG_AW(5), .CNT_W(32)) u_dut (.clk(clk), .reset(reset), .hz(hz.slave));
  hazard_ctrl #(.REG_AW(5), .CNT_W(4))  u_sat (.clk(clk), .reset(reset), .hz(hs.slave));

  assign hs.id_valid        = hz.id_valid;
  assign hs.id_rs1          = hz.id_rs1;
  assign hs.id_rs2          = hz.id_rs2;
  assign hs.id_uses_rs2     = hz.id_uses_rs2;
  assign hs.id_rd           = hz.id_rd;
  assign hs.id_regwrite     = hz.id_regwrite;
  assign hs.id_memread      = hz.id_memread;
  assign hs.id_branch       = hz.id_branch;
  assign hs.ex_branch_taken = hz.ex_branch_taken;

  typedef struct packed {
    bit       v;
    bit [4:0] rd, rs1, rs2;
    bit       u2, rw, mr, br;
  } ins_t;

  ins_t   st [3];           // 0 = EX, 1 = MEM, 2 = WB
  longint stall_n, flush_n;
  bit     e_brf, e_lu;
  int     vectors = 0;
  int     miscompares = 0;

  function automatic bit writes(ins_t s, bit [4:0] r);
    return s.v && s.rw && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(bit [4:0] r);
    if (writes(st[1], r) && !st[1].mr) return 2'b10;
    if (writes(st[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic longint sat(longint n, int w);
    longint m = (longint'(1) << w) - 1;
    return (n > m) ? m : n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) st[i] = '0;
    stall_n = 0;
    flush_n = 0;
    e_brf = 1'b0;
    e_lu = 1'b0;
  endtask

  task automatic check_outputs();
    bit brf, lu;
    brf = st[0].v && st[0].br && hz.ex_branch_taken;
    lu  = hz.id_valid && st[0].v && st[0].mr && (st[0].rd != 5'd0) &&
          ((st[0].rd == hz.id_rs1) || (hz.id_uses_rs2 && (st[0].rd == hz.id_rs2)));
    e_brf = brf;
    e_lu  = lu;
    chk("pc_write",    32'(hz.pc_write),    32'(brf || !lu));
    chk("ifid_write",  32'(hz.ifid_write),  32'(brf || !lu));
    chk("ifid_flush",  32'(hz.ifid_flush),  32'(brf));
    chk("idex_bubble", 32'(hz.idex_bubble), 32'(brf || lu));
    chk("fwd_a",       32'(hz.fwd_a),       32'(fwd_sel(st[0].rs1)));
    chk("fwd_b",       32'(hz.fwd_b),       32'(st[0].u2 ? fwd_sel(st[0].rs2) : 2'b00));
    chk("id_bypass_a", 32'(hz.id_bypass_a), 32'(hz.id_valid && writes(st[2], hz.id_rs1)));
    chk("id_bypass_b", 32'(hz.id_bypass_b),
        32'(hz.id_valid && hz.id_uses_rs2 && writes(st[2], hz.id_rs2)));
    chk("stall_count", hz.stall_count, 32'(sat(stall_n, 32)));
    chk("flush_count", hz.flush_count, 32'(sat(flush_n, 32)));
    chk("sat_stall",   32'(hs.stall_count), 32'(sat(stall_n, 4)));
    chk("sat_flush",   32'(hs.flush_count), 32'(sat(flush_n, 4)));
  endtask

  task automatic advance();
    if (e_lu && !e_brf) stall_n++;
    if (e_brf) flush_n++;
    st[2] = st[1];
    st[1] = st[0];
    if (e_brf || e_lu) st[0] = '0;
    else st[0] = '{v: hz.id_valid, rd: hz.id_rd, rs1: hz.id_rs1, rs2: hz.id_rs2,
                   u2: hz.id_uses_rs2, rw: hz.id_regwrite, mr: hz.id_memread,
                   br: hz.id_branch};
  endtask

  // Check at the falling edge, then let the rising edge move the pipeline.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic drive(bit v, bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                       bit u2, bit rw, bit mr, bit br, bit taken);
    hz.id_valid = v;
    hz.id_rd = rd;
    hz.id_rs1 = rs1;
    hz.id_rs2 = rs2;
    hz.id_uses_rs2 = u2;
    hz.id_regwrite = rw;
    hz.id_memread = mr;
    hz.id_branch = br;
    hz.ex_branch_taken = taken;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #1;
    chk("rst_pc_write",    32'(hz.pc_write), 32'd1);
    chk("rst_ifid_write",  32'(hz.ifid_write), 32'd1);
    chk("rst_idex_bubble", 32'(hz.idex_bubble), 32'd0);
    chk("rst_ifid_flush",  32'(hz.ifid_flush), 32'd0);
    chk("rst_stall_count", hz.stall_count, 32'd0);
    chk("rst_flush_count", hz.flush_count, 32'd0);
    chk("rst_sat_stall",   32'(hs.stall_count), 32'd0);
    do_reset();
  endtask

  initial begin
    int guard;
    do_reset();
    step();
    chk("reset_fwd_a", 32'(hz.fwd_a), 32'd0);

    // ld x1 then add x3,x1,x2 (0x002081B3): one stall, then WB forward on rs1
    drive(1, 1, 0, 0, 0, 1, 1, 0, 0); step();
    drive(1, 3, 1, 2, 1, 1, 0, 0, 0); step();
    chk("lu_one_stall", hz.stall_count, 32'd1);
    step();
    chk("lu_fwd_a_wb", 32'(hz.fwd_a), 32'd1);
    chk("lu_fwd_b_rf", 32'(hz.fwd_b), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // add x3,x1,x2 then sub x4,x3,x3: EX/MEM forward both operands
    drive(1, 3, 1, 2, 1, 1, 0, 0, 0); step();
    drive(1, 4, 3, 3, 1, 1, 0, 0, 0); step();
    chk("alu_fwd_a_mem", 32'(hz.fwd_a), 32'd2);
    chk("alu_fwd_b_mem", 32'(hz.fwd_b), 32'd2);
    drive(1, 0, 1, 2, 1, 1, 0, 0, 0); step();
    drive(1, 5, 0, 0, 1, 1, 0, 0, 0); step();
    chk("x0_fwd_a", 32'(hz.fwd_a), 32'd0);
    chk("x0_fwd_b", 32'(hz.fwd_b), 32'd0);
    chk("no_stall_alu", hz.stall_count, 32'd1);

    // beq x1,x2,12 (0x00208663) taken, then not taken
    drive(1, 0, 1, 2, 1, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("br_flush_count", hz.flush_count, 32'd1);
    drive(1, 0, 1, 2, 1, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("br_not_taken", hz.flush_count, 32'd1);

    // Load with forced branch in EX plus dependent ID: flush wins
    drive(1, 5, 0, 0, 0, 1, 1, 1, 0); step();
    drive(1, 6, 5, 0, 0, 1, 0, 0, 1); step();
    chk("prio_stall_same", hz.stall_count, 32'd1);
    chk("prio_flush_inc",  hz.flush_count, 32'd2);
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0); step();
    chk("wb_bypass_a", 32'(hz.id_bypass_a), 32'd1);

    // Repeated ld x1,0(x1) stalls every other cycle and saturates the 4-bit twin
    drive(1, 1, 1, 0, 0, 1, 1, 0, 0);
    repeat (40) step();
    chk("sat_at_f", 32'(hs.stall_count), 32'hF);
    guard = 0;
    while (!(st[0].v && st[0].mr) && guard < 4) begin
      step();
      guard++;
    end
    chk("stall_reached", 32'(guard < 4), 32'd1);
    chk("mid_stall", 32'(hz.pc_write), 32'd0);
    async_reset_check();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset_check();
      drive(bit'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0),
            bit'($urandom_range(0, 1)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
